// File: rtl/alu_serial_pkg.sv
// rtl/alu_serial_pkg.sv - op codes, FSM states and flag indices for alu_serial
// Optional shift ops RL/SLA are enabled by defining ALU_SERIAL_SHIFT_EN.
package alu_serial_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_CP  = 4'd7;
    localparam logic [3:0] OP_RL  = 4'd8;
    localparam logic [3:0] OP_SLA = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    function automatic logic op_supported(input logic [3:0] op);
`ifdef ALU_SERIAL_SHIFT_EN
        return op <= OP_SLA;
`else
        return op <= OP_CP;
`endif
    endfunction

    // Ops whose first slice consumes the C flag as carry/borrow-in.
    function automatic logic op_takes_carry(input logic [3:0] op);
`ifdef ALU_SERIAL_SHIFT_EN
        return (op == OP_ADC) || (op == OP_SBC) || (op == OP_RL);
`else
        return (op == OP_ADC) || (op == OP_SBC);
`endif
    endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// rtl/alu_serial_slice.sv - combinational one-slice datapath of alu_serial
// RL/SLA cases exist only when ALU_SERIAL_SHIFT_EN is defined.
module alu_serial_slice
    import alu_serial_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carry_in,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              half_out
);

    localparam int HALF_W = DATA_W / 2;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, carry_in};
    assign diff = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, carry_in};

    // Carry/borrow into bit HALF_W is recovered from the operand and result bits.
    always_comb begin
        result    = a;
        carry_out = 1'b0;
        half_out  = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
                half_out  = a[HALF_W] ^ b[HALF_W] ^ sum[HALF_W];
            end
            OP_SUB, OP_SBC, OP_CP: begin
                result    = diff[DATA_W-1:0];
                carry_out = diff[DATA_W];
                half_out  = a[HALF_W] ^ b[HALF_W] ^ diff[HALF_W];
            end
            OP_AND: begin
                result   = a & b;
                half_out = 1'b1;
            end
            OP_XOR: result = a ^ b;
            OP_OR:  result = a | b;
`ifdef ALU_SERIAL_SHIFT_EN
            OP_RL, OP_SLA: begin
                result    = {a[DATA_W-2:0], carry_in};
                carry_out = a[DATA_W-1];
            end
`endif
            default: result = a;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - serial multi-slice ALU with Z/N/H/C flags and start/busy/done handshake
// Define ALU_SERIAL_SHIFT_EN to add the RL/SLA shift ops.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 2,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic                          i_Enable,
    input  logic                          i_Start,
    input  logic [3:0]                    i_Op,
    input  logic [LEN_W-1:0]              i_Len,
    input  logic [MAX_BYTES*DATA_W-1:0]   i_A,
    input  logic [MAX_BYTES*DATA_W-1:0]   i_B,
    input  logic                          i_Save_Flags,
    input  logic                          i_Flags_Write,
    input  logic [3:0]                    i_Flags_Data,
    output logic                          o_Busy,
    output logic                          o_Done,
    output logic [MAX_BYTES*DATA_W-1:0]   o_Result,
    output logic [3:0]                    o_Flags
);

    localparam int TOT_W = MAX_BYTES * DATA_W;

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [TOT_W-1:0]    a_q, a_d;
    logic [TOT_W-1:0]    b_q, b_d;
    logic                save_q, save_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                half_q, half_d;
    logic                zero_q, zero_d;
    logic [TOT_W-1:0]    result_q, result_d;
    logic [3:0]          flags_q, flags_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [LEN_W-1:0]    eff_len;
    logic [DATA_W-1:0]   sl_a, sl_b, sl_result;
    logic                sl_carry, sl_half;
    logic                keep_a;
    logic [3:0]          done_flags;

    assign sl_a   = a_q[int'(idx_q)*DATA_W +: DATA_W];
    assign sl_b   = b_q[int'(idx_q)*DATA_W +: DATA_W];
    assign keep_a = (op_q == OP_CP) || !op_supported(op_q);

    alu_serial_slice #(
        .DATA_W    (DATA_W)
    ) u_slice (
        .a         (sl_a),
        .b         (sl_b),
        .carry_in  (carry_q),
        .op        (op_q),
        .result    (sl_result),
        .carry_out (sl_carry),
        .half_out  (sl_half)
    );

    always_comb begin
        if (i_Len == '0) begin
            eff_len = LEN_W'(1);
        end else if (i_Len > LEN_W'(MAX_BYTES)) begin
            eff_len = LEN_W'(MAX_BYTES);
        end else begin
            eff_len = i_Len;
        end
    end

    always_comb begin
        case (op_q)
            OP_ADD, OP_ADC:        done_flags = {zero_q, 1'b0, half_q, carry_q};
            OP_SUB, OP_SBC, OP_CP: done_flags = {zero_q, 1'b1, half_q, carry_q};
            OP_AND:                done_flags = {zero_q, 1'b0, 1'b1, 1'b0};
`ifdef ALU_SERIAL_SHIFT_EN
            OP_RL, OP_SLA:         done_flags = {zero_q, 1'b0, 1'b0, carry_q};
`endif
            default:               done_flags = {zero_q, 1'b0, 1'b0, 1'b0};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        save_d   = save_q;
        len_d    = len_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        half_d   = half_q;
        zero_d   = zero_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d  = ST_RUN;
                    op_d     = i_Op;
                    a_d      = i_A;
                    b_d      = i_B;
                    save_d   = i_Save_Flags;
                    len_d    = eff_len;
                    idx_d    = '0;
                    carry_d  = op_takes_carry(i_Op) ? flags_q[FLAG_C] : 1'b0;
                    half_d   = 1'b0;
                    zero_d   = 1'b1;
                    result_d = '0;
                end
            end
            ST_RUN: begin
                result_d[int'(idx_q)*DATA_W +: DATA_W] = keep_a ? sl_a : sl_result;
                carry_d = sl_carry;
                half_d  = sl_half;
                zero_d  = zero_q & ~(|sl_result);
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (save_q && op_supported(op_q)) begin
                    flags_d = done_flags;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A direct load overrides a same-cycle completion writeback.
        if (i_Flags_Write) begin
            flags_d = i_Flags_Data;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            save_q   <= 1'b0;
            len_q    <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            half_q   <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= 4'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (i_Enable) begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            save_q   <= save_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            half_q   <= half_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_Busy   = busy_q;
    assign o_Done   = done_q;
    assign o_Result = result_q;
    assign o_Flags  = flags_q;

endmodule

// File: tb/tb_alu_serial.sv
// tb/tb_alu_serial.sv - scoreboard bench for alu_serial (define ALU_SERIAL_SHIFT_EN to cover RL/SLA)
module tb_alu_serial;

    localparam int DW = 8;
    localparam int MB = 2;
    localparam int LW = $clog2(MB + 1);
    localparam int TW = MB * DW;
`ifdef ALU_SERIAL_SHIFT_EN
    localparam bit SHIFT = 1'b1;
`else
    localparam bit SHIFT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          start;
    logic [3:0]    op;
    logic [LW-1:0] len;
    logic [TW-1:0] a, b;
    logic          save;
    logic          fw;
    logic [3:0]    fd;
    logic          busy, done;
    logic [TW-1:0] res;
    logic [3:0]    flags;

    always #5 clk = ~clk;

    alu_serial #(.DATA_W(DW), .MAX_BYTES(MB)) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Enable      (en),
        .i_Start       (start),
        .i_Op          (op),
        .i_Len         (len),
        .i_A           (a),
        .i_B           (b),
        .i_Save_Flags  (save),
        .i_Flags_Write (fw),
        .i_Flags_Data  (fd),
        .o_Busy        (busy),
        .o_Done        (done),
        .o_Result      (res),
        .o_Flags       (flags)
    );

    typedef struct {
        longint     res;
        logic [3:0] flags;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         n_done = 0;
    longint     cyc = 0;
    longint     start_cyc = 0;
    logic [3:0] model_flags = 4'h0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Whole-operand arithmetic reference: n slices treated as one n*DW-bit number.
    function automatic void model(input int o, input int n, input longint av_in, input longint bv_in,
                                  input logic sv, input logic [3:0] fl,
                                  output longint r, output logic [3:0] nf);
        longint mask, lmask, hm, av, bv, ta, tbv, full, part, hpart, ci;
        logic   z, nn, h, c, wr;
        int     sh;
        sh    = (n - 1) * DW;
        mask  = (64'sd1 <<< (n * DW)) - 1;
        lmask = (64'sd1 <<< sh) - 1;
        hm    = (64'sd1 <<< (DW / 2)) - 1;
        av    = av_in & mask;
        bv    = bv_in & mask;
        ta    = av >> sh;
        tbv   = bv >> sh;
        wr = 1'b1; nn = 1'b0; h = 1'b0; c = 1'b0; r = av;
        case (o)
            0, 1: begin
                ci    = (o == 1 && fl[0]) ? 1 : 0;
                full  = av + bv + ci;
                r     = full & mask;
                c     = full[n * DW];
                part  = (av & lmask) + (bv & lmask) + ci;
                hpart = (ta & hm) + (tbv & hm) + (part >> sh);
                h     = hpart[DW / 2];
            end
            2, 3, 7: begin
                ci    = (o == 3 && fl[0]) ? 1 : 0;
                full  = av - bv - ci;
                r     = full & mask;
                c     = (full < 0);
                part  = ((av & lmask) - (bv & lmask) - ci < 0) ? 1 : 0;
                h     = ((ta & hm) - (tbv & hm) - part) < 0;
                nn    = 1'b1;
            end
            4: begin r = av & bv; h = 1'b1; end
            5: r = av ^ bv;
            6: r = av | bv;
            8, 9: begin
                if (SHIFT) begin
                    ci = (o == 8 && fl[0]) ? 1 : 0;
                    r  = ((av << 1) | ci) & mask;
                    c  = av[n * DW - 1];
                end else begin
                    wr = 1'b0;
                end
            end
            default: wr = 1'b0;
        endcase
        z = (r == 0);
        if (o == 7) r = av;
        nf = (sv && wr) ? {z, nn, h, c} : fl;
    endfunction

    // Monitor: pops one expectation per o_Done rising edge; flags checked once idle again.
    logic       done_prev = 1'b0;
    logic       flags_pending = 1'b0;
    logic [3:0] flags_exp_pend;
    always @(negedge clk) begin
        exp_t e;
        if (flags_pending && !busy) begin
            check("flags", longint'(flags), longint'(flags_exp_pend));
            flags_pending = 1'b0;
        end
        if (done && !done_prev) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("result", longint'(res), e.res);
                check("latency", cyc - start_cyc, longint'(e.lat));
                flags_exp_pend = e.flags;
                flags_pending  = 1'b1;
            end
        end
        done_prev = done;
    end

    task automatic set_flags(input logic [3:0] v);
        @(posedge clk); #1;
        fw = 1'b1; fd = v;
        @(posedge clk); #1;
        fw = 1'b0;
        model_flags = v;
        @(negedge clk);
        check("flags_write", longint'(flags), longint'(v));
    endtask

    // stall_mode: 0 none, 1 three stalled cycles early in RUN, 2 random enable.
    task automatic run_op(input logic [3:0] o, input logic [LW-1:0] l, input logic [TW-1:0] av,
                          input logic [TW-1:0] bv, input logic sv, input int stall_mode, input bit restart);
        bit         en_pat[32];
        int         n, lat, cnt, k;
        longint     r;
        logic [3:0] nf;
        exp_t       e;
        n = (l == 0) ? 1 : ((int'(l) > MB) ? MB : int'(l));
        for (int i = 0; i < 32; i++) begin
            if (i == 0 || i >= 16 || stall_mode == 0) en_pat[i] = 1'b1;
            else if (stall_mode == 1) en_pat[i] = !(i >= 2 && i <= 4);
            else en_pat[i] = ($urandom_range(0, 3) != 0);
        end
        lat = 0; cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (en_pat[i]) cnt++;
            if (cnt == n + 1) begin lat = i + 1; break; end
        end
        model(int'(o), n, longint'(av), longint'(bv), sv, model_flags, r, nf);
        model_flags = nf;
        e.res = r; e.flags = nf; e.lat = lat;
        sb.push_back(e);

        @(posedge clk); #1;
        op = o; len = l; a = av; b = bv; save = sv; start = 1'b1; en = 1'b1;
        start_cyc = cyc;
        k = 1;
        while (1) begin
            @(posedge clk); #1;
            if (!busy) break;
            if (k > 100) begin
                check("timeout", 1, 0);
                break;
            end
            en    = (k < 32) ? en_pat[k] : 1'b1;
            start = restart && busy && !done;
            if (restart) begin
                op = 4'($urandom); a = TW'($urandom); b = TW'($urandom); save = 1'($urandom);
            end
            k++;
        end
        start = 1'b0;
        en    = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nd;
        rst = 1'b1; en = 1'b1; start = 1'b0; op = '0; len = '0; a = '0; b = '0;
        save = 1'b0; fw = 1'b0; fd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_result", longint'(res), 0);
        check("reset_flags", longint'(flags), 0);

        run_op(4'd0, 2'd2, 16'h0FFF, 16'h0001, 1'b1, 0, 1'b0);
        run_op(4'd2, 2'd1, 16'h0010, 16'h0010, 1'b1, 0, 1'b0);
        set_flags(4'b0001);
        run_op(4'd1, 2'd2, 16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        run_op(4'd7, 2'd1, 16'h0005, 16'h0006, 1'b1, 0, 1'b0);
        run_op(4'd7, 2'd1, 16'h0033, 16'h0033, 1'b0, 0, 1'b0);
        run_op(4'd0, 2'd2, 16'h1234, 16'h4321, 1'b1, 1, 1'b1);
        run_op(4'd0, 2'd0, 16'hABFF, 16'h0001, 1'b1, 0, 1'b0);
        run_op(4'd4, 2'd3, 16'hF0F0, 16'h0FF0, 1'b1, 0, 1'b0);
        run_op(4'd12, 2'd2, 16'hBEEF, 16'h1111, 1'b1, 0, 1'b0);

        // Reset in the second RUN cycle: no completion, outputs back to reset values.
        set_flags(4'hF);
        nd = n_done;
        @(posedge clk); #1;
        op = 4'd0; len = 2'd2; a = 16'h1234; b = 16'h1111; save = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        check("partial_result", longint'(res), 64'h0045);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_flags = 4'h0;
        @(negedge clk);
        check("rst_run_busy", longint'(busy), 0);
        check("rst_run_result", longint'(res), 0);
        check("rst_run_flags", longint'(flags), 0);
        repeat (6) @(posedge clk);
        check("rst_run_no_done", longint'(n_done), longint'(nd));

`ifdef ALU_SERIAL_SHIFT_EN
        run_op(4'd8, 2'd2, 16'h8001, 16'h0000, 1'b1, 0, 1'b0);
        set_flags(4'b0001);
        run_op(4'd8, 2'd2, 16'h4000, 16'h0000, 1'b1, 0, 1'b0);
        run_op(4'd9, 2'd1, 16'h00C1, 16'h0000, 1'b1, 0, 1'b0);
`endif

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) set_flags(4'($urandom));
            run_op(4'($urandom_range(0, 15)), LW'($urandom_range(0, 3)), TW'($urandom), TW'($urandom),
                   1'($urandom), 2 * int'($urandom_range(0, 1)), 1'($urandom));
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
